// File: rtl/seq_detector_param.sv
// Serial detector for a programmable PAT_LEN-symbol pattern.
// Supports overlap/flush matching, an in-band clear symbol and a saturating hit counter.
module seq_detector_param #(
  parameter int                         SYM_W     = 2,
  parameter int                         PAT_LEN   = 4,
  parameter logic [PAT_LEN*SYM_W-1:0]   PAT_INIT  = 8'h62,
  parameter bit                         CLEAR_EN  = 1'b1,
  parameter logic [SYM_W-1:0]           CLEAR_SYM = 2'b11,
  parameter int                         CNT_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [SYM_W-1:0]               in_sym,
  input  logic                           overlap,
  input  logic                           pat_wr,
  input  logic [$clog2(PAT_LEN)-1:0]     pat_idx,
  input  logic [SYM_W-1:0]               pat_data,
  input  logic                           cnt_clr,
  output logic                           match,
  output logic [CNT_W-1:0]               match_cnt,
  output logic                           cnt_sat,
  output logic [$clog2(PAT_LEN+1)-1:0]   fill
);

  localparam int W  = PAT_LEN * SYM_W;
  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

  logic [W-1:0]     pat_q;
  logic [W-1:0]     pat_d;
  logic [W-1:0]     hist_q;
  logic [W-1:0]     hist_d;
  logic [W-1:0]     hist_sh;
  logic [FW-1:0]    fill_d;
  logic [FW-1:0]    fill_inc;
  logic [CNT_W-1:0] cnt_d;
  logic             sat_d;
  logic             match_d;
  logic             hit;
  logic             is_clr;
  logic             idx_ok;

  // Oldest symbol lives in slot 0, so shifting right ages the history.
  assign hist_sh  = {in_sym, hist_q[W-1:SYM_W]};
  assign fill_inc = (fill == FULL) ? FULL : fill + 1'b1;
  assign hit      = (hist_sh == pat_q) && (fill_inc == FULL);
  assign is_clr   = CLEAR_EN && (in_sym == CLEAR_SYM);
  assign idx_ok   = 32'(pat_idx) < PAT_LEN;

  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill;
    match_d = 1'b0;
    if (pat_wr) begin
      if (idx_ok) begin
        pat_d[pat_idx*SYM_W +: SYM_W] = pat_data;
      end
      fill_d = '0;
    end else if (in_valid && is_clr) begin
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = hist_sh;
      fill_d = fill_inc;
      if (hit) begin
        match_d = 1'b1;
        if (!overlap) begin
          fill_d = '0;
        end
      end
    end
  end

  // Clear beats a simultaneous hit; saturation is sticky until cleared.
  always_comb begin
    cnt_d = match_cnt;
    sat_d = cnt_sat;
    if (cnt_clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (match_d && !(&match_cnt)) begin
      cnt_d = match_cnt + 1'b1;
      sat_d = cnt_sat | (&cnt_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q     <= PAT_INIT;
      hist_q    <= '0;
      fill      <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      hist_q    <= hist_d;
      fill      <= fill_d;
      match     <= match_d;
      match_cnt <= cnt_d;
      cnt_sat   <= sat_d;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus biased random traffic
// checked against a queue-based reference model (8-bit and 2-bit counter instances).
module tb_seq_detector_param;

  localparam int PL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_sym = '0;
  logic       overlap = 1'b0;
  logic       pat_wr = 1'b0;
  logic [1:0] pat_idx = '0;
  logic [1:0] pat_data = '0;
  logic       cnt_clr = 1'b0;

  logic       match_a;
  logic [7:0] cnt_a;
  logic       sat_a;
  logic [2:0] fill_a;
  logic       match_b;
  logic [1:0] cnt_b;
  logic       sat_b;
  logic [2:0] fill_b;

  seq_detector_param u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym),
    .overlap(overlap), .pat_wr(pat_wr), .pat_idx(pat_idx),
    .pat_data(pat_data), .cnt_clr(cnt_clr), .match(match_a),
    .match_cnt(cnt_a), .cnt_sat(sat_a), .fill(fill_a)
  );

  seq_detector_param #(.CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym),
    .overlap(overlap), .pat_wr(pat_wr), .pat_idx(pat_idx),
    .pat_data(pat_data), .cnt_clr(cnt_clr), .match(match_b),
    .match_cnt(cnt_b), .cnt_sat(sat_b), .fill(fill_b)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "reset";

  int q[$];
  int pat[PL];
  int em, c8, c2, s8, s2;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s [%s] observed=%0h expected=%0h", tag, phase, obs, expv);
    end
  endtask

  task automatic check_all();
    check("match_a", 32'(match_a), 32'(em));
    check("match_b", 32'(match_b), 32'(em));
    check("cnt_a", 32'(cnt_a), 32'(c8));
    check("cnt_b", 32'(cnt_b), 32'(c2));
    check("sat_a", 32'(sat_a), 32'(s8));
    check("sat_b", 32'(sat_b), 32'(s2));
    check("fill_a", 32'(fill_a), 32'(q.size()));
    check("fill_b", 32'(fill_b), 32'(q.size()));
  endtask

  task automatic model_reset();
    q.delete();
    pat = '{2, 0, 2, 1};
    em = 0; c8 = 0; c2 = 0; s8 = 0; s2 = 0;
  endtask

  task automatic model(input int v, input int s, input int ov, input int wr,
                       input int idx, input int d, input int clr);
    int hit;
    hit = 0;
    if (wr != 0) begin
      if (idx < PL) pat[idx] = d;
      q.delete();
    end else if (v != 0 && s == 3) begin
      q.delete();
    end else if (v != 0) begin
      q.push_back(s);
      if (q.size() > PL) void'(q.pop_front());
      hit = (q.size() == PL) ? 1 : 0;
      for (int i = 0; i < q.size(); i++)
        if (q[i] != pat[i]) hit = 0;
      if (hit != 0 && ov == 0) q.delete();
    end
    em = hit;
    if (clr != 0) begin
      c8 = 0; c2 = 0; s8 = 0; s2 = 0;
    end else if (hit != 0) begin
      if (c8 < 255) c8++;
      if (c8 == 255) s8 = 1;
      if (c2 < 3) c2++;
      if (c2 == 3) s2 = 1;
    end
  endtask

  task automatic step(input int v, input int s, input int ov, input int wr,
                      input int idx, input int d, input int clr);
    in_valid = v[0];
    in_sym   = s[1:0];
    overlap  = ov[0];
    pat_wr   = wr[0];
    pat_idx  = idx[1:0];
    pat_data = d[1:0];
    cnt_clr  = clr[0];
    @(posedge clk);
    model(v, s, ov, wr, idx, d, clr);
    #1;
    check_all();
    in_valid = 1'b0;
    pat_wr   = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic sym(input int s, input int ov);
    step(1, s, ov, 0, 0, 0, 0);
  endtask

  task automatic wrp(input int idx, input int d);
    step(0, 0, 0, 1, idx, d, 0);
  endtask

  task automatic clr_step();
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  // Asserted between clock edges so the async path is what clears outputs.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r, s;
    do_reset();

    phase = "T1";
    sym(2, 0); sym(0, 0); sym(2, 0); sym(1, 0);
    check("t1_match", 32'(match_a), 32'd1);
    check("t1_cnt", 32'(cnt_a), 32'd1);
    check("t1_fill", 32'(fill_a), 32'd0);
    sym(0, 0);
    check("t1_pulse", 32'(match_a), 32'd0);

    phase = "T2";
    clr_step();
    wrp(0, 2); wrp(1, 0); wrp(2, 2); wrp(3, 0);
    for (int i = 0; i < 6; i++) sym((i % 2 == 0) ? 2 : 0, 1);
    check("t2_ov_cnt", 32'(cnt_a), 32'd2);
    sym(3, 0);
    clr_step();
    for (int i = 0; i < 6; i++) sym((i % 2 == 0) ? 2 : 0, 0);
    check("t2_nov_cnt", 32'(cnt_a), 32'd1);

    phase = "T3";
    clr_step();
    wrp(0, 2); wrp(1, 0); wrp(2, 2); wrp(3, 1);
    sym(2, 0); sym(0, 0); sym(3, 0);
    check("t3_fill", 32'(fill_a), 32'd0);
    sym(2, 0); sym(0, 0); sym(2, 0); sym(1, 0);
    check("t3_match", 32'(match_a), 32'd1);
    check("t3_cnt", 32'(cnt_a), 32'd1);

    phase = "T4";
    clr_step();
    for (int i = 0; i < PL; i++) wrp(i, 1);
    for (int i = 0; i < 8; i++) sym(1, 1);
    check("t4_cnt_a", 32'(cnt_a), 32'd5);
    check("t4_cnt_b", 32'(cnt_b), 32'd3);
    check("t4_sat_b", 32'(sat_b), 32'd1);
    step(1, 1, 1, 0, 0, 0, 1);
    check("t4_clr_match", 32'(match_b), 32'd1);
    check("t4_clr_cnt", 32'(cnt_b), 32'd0);

    phase = "T5";
    wrp(0, 2); wrp(1, 0); wrp(2, 2); wrp(3, 1);
    sym(2, 0); sym(0, 0);
    step(1, 2, 0, 1, 0, 2, 0);
    check("t5_fill", 32'(fill_a), 32'd0);
    sym(1, 0);
    check("t5_nomatch", 32'(match_a), 32'd0);
    sym(2, 0); sym(0, 0); sym(2, 0); sym(1, 0);
    check("t5_match", 32'(match_a), 32'd1);

    phase = "T6";
    wrp(0, 1);
    sym(2, 0); sym(0, 0); sym(2, 0);
    do_reset();
    check("t6_fill", 32'(fill_a), 32'd0);
    sym(1, 0);
    check("t6_nomatch", 32'(match_a), 32'd0);
    sym(2, 0); sym(0, 0); sym(2, 0); sym(1, 0);
    check("t6_init_pat", 32'(match_a), 32'd1);

    phase = "random";
    for (int k = 0; k < 2000; k++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 3) != 0) s = pat[q.size() % PL];
      else s = int'($urandom_range(0, 3));
      if (r < 1) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) != 0) ? 1 : 0, s,
             int'($urandom_range(0, 1)), (r < 5) ? 1 : 0,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             (r >= 97) ? 1 : 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
